// File: rtl/prism_anim_sequencer.sv
// prism_anim_sequencer
//   Frame-rate animation sequencer for the prism pixel datapath. Detects the
//   rising edge of vsync to produce one frame_tick per frame, advances an
//   animation phase on each unpaused frame (or single-stepped while paused),
//   and cycles through four scenes with an optional fade-out / fade-in of the
//   colour mask around every scene switch.
//
//   Build option: define PRISM_SEQ_FADE_EN to include the FADE_OUT/FADE_IN
//   states and the fade level; without it the mask is mask_in registered and
//   the FSM goes RUN -> SWITCH -> RUN.
//
//   Ports
//     clk         in   sole clock, rising edge
//     reset       in   synchronous active-high reset
//     vsync       in   vertical sync, synchronous to clk
//     speed[1:0]  in   phase step exponent, step = 1 << speed
//     pause       in   freeze animation while high
//     step_req    in   level request for one advance while paused
//     mask_in[5:0] in  user colour mask {b1,b0,g1,g0,r1,r0}
//     frame_tick  out  one-cycle pulse per frame
//     step_ack    out  one-cycle acknowledge of a consumed step_req
//     anim_count[9:0] out animation phase
//     scene[1:0]  out  current scene index
//     color_mask[5:0] out mask applied to the datapath colour bits
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   RUN      | dwelling in the current scene, counting advances
//   FADE_OUT | stepping the fade level down 3 -> 0, one per advance
//   SWITCH   | single cycle, moves to the next scene
//   FADE_IN  | stepping the fade level up 0 -> 3, one per advance
module prism_anim_sequencer #(
    parameter int DWELL_FRAMES = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vsync,
    input  logic [1:0] speed,
    input  logic       pause,
    input  logic       step_req,
    input  logic [5:0] mask_in,
    output logic       frame_tick,
    output logic       step_ack,
    output logic [9:0] anim_count,
    output logic [1:0] scene,
    output logic [5:0] color_mask
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FADE_OUT = 2'd1,
        ST_SWITCH   = 2'd2,
        ST_FADE_IN  = 2'd3
    } state_t;

    localparam logic [7:0] DWELL_LAST = 8'(DWELL_FRAMES - 1);

    logic       r_vs_q;
    logic       r_frame_tick;
    logic       r_step_ack;
    logic [9:0] r_anim;
    logic [1:0] r_scene;
    logic [7:0] r_dwell;
    logic [5:0] r_mask;
    state_t     r_state;

    state_t     w_state_nxt;
    logic [7:0] w_dwell_nxt;
    logic [1:0] w_scene_nxt;
    logic [5:0] w_mask_nxt;
    logic       w_advance;
    logic       w_step_used;
    logic [9:0] w_anim_step;

`ifdef PRISM_SEQ_FADE_EN
    logic [1:0] r_fade;
    logic [1:0] w_fade_nxt;
`endif

    // step_req only counts while paused; unpaused frames advance anyway.
    assign w_advance   = r_frame_tick & (~pause | step_req);
    assign w_step_used = r_frame_tick & pause & step_req;
    assign w_anim_step = 10'd1 << speed;

    always_comb begin
        w_state_nxt = r_state;
        w_dwell_nxt = r_dwell;
        w_scene_nxt = r_scene;
`ifdef PRISM_SEQ_FADE_EN
        w_fade_nxt  = r_fade;
`endif
        case (r_state)
            ST_RUN: begin
                if (w_advance) begin
                    if (r_dwell == DWELL_LAST) begin
                        w_dwell_nxt = 8'd0;
`ifdef PRISM_SEQ_FADE_EN
                        w_state_nxt = ST_FADE_OUT;
`else
                        w_state_nxt = ST_SWITCH;
`endif
                    end else begin
                        w_dwell_nxt = r_dwell + 8'd1;
                    end
                end
            end
            // SWITCH does not wait for an advance.
            ST_SWITCH: begin
                w_scene_nxt = r_scene + 2'd1;
`ifdef PRISM_SEQ_FADE_EN
                w_state_nxt = ST_FADE_IN;
`else
                w_state_nxt = ST_RUN;
`endif
            end
`ifdef PRISM_SEQ_FADE_EN
            ST_FADE_OUT: begin
                if (w_advance) begin
                    if (r_fade == 2'd0) begin
                        w_state_nxt = ST_SWITCH;
                    end else begin
                        w_fade_nxt = r_fade - 2'd1;
                    end
                end
            end
            ST_FADE_IN: begin
                if (w_advance) begin
                    if (r_fade == 2'd3) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_fade_nxt = r_fade + 2'd1;
                    end
                end
            end
`endif
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // Mask follows the next fade level so it lines up with the state change.
    always_comb begin
`ifdef PRISM_SEQ_FADE_EN
        case (w_fade_nxt)
            2'd3:    w_mask_nxt = mask_in;
            2'd2:    w_mask_nxt = mask_in & 6'b101010;
            2'd1:    w_mask_nxt = mask_in & 6'b100000;
            default: w_mask_nxt = 6'b000000;
        endcase
`else
        w_mask_nxt = mask_in;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // vs_q starts high so a vsync already high at release is not a tick.
            r_vs_q       <= 1'b1;
            r_frame_tick <= 1'b0;
            r_step_ack   <= 1'b0;
            r_anim       <= 10'd0;
            r_scene      <= 2'd0;
            r_dwell      <= 8'd0;
            r_state      <= ST_RUN;
            r_mask       <= mask_in;
`ifdef PRISM_SEQ_FADE_EN
            r_fade       <= 2'd3;
`endif
        end else begin
            r_vs_q       <= vsync;
            r_frame_tick <= vsync & ~r_vs_q;
            r_step_ack   <= w_step_used;
            if (w_advance) begin
                r_anim <= r_anim + w_anim_step;
            end
            r_scene      <= w_scene_nxt;
            r_dwell      <= w_dwell_nxt;
            r_state      <= w_state_nxt;
            r_mask       <= w_mask_nxt;
`ifdef PRISM_SEQ_FADE_EN
            r_fade       <= w_fade_nxt;
`endif
        end
    end

    assign frame_tick = r_frame_tick;
    assign step_ack   = r_step_ack;
    assign anim_count = r_anim;
    assign scene      = r_scene;
    assign color_mask = r_mask;

endmodule
